time_code_buffer: RTL and testbench
===================================

# time_code_buffer

Buffers the 64-bit time codes produced by the time-code combination stage (`w_en`/`w_data`, `{seconds[31:0], nanoseconds[31:0]}`) and hands them to the 32-bit register-read path as two consecutive words. It sits directly downstream of the combination stage in the time_top hierarchy. It absorbs bursts of timestamp events while software is slow to read, and flags overflow when it cannot keep up.

## Interface
- `DEPTH`, 16: number of 64-bit entries; power of two, 2..256.
- `AW`, 4: log2(DEPTH).

- `sclk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `w_en` in 1: single-cycle write strobe from the combination stage.
- `w_data` in 64: time code; [63:32] seconds, [31:0] nanoseconds.
- `rd_req` in 1: read request for one 32-bit word.
- `clr` in 1: synchronous flush and clear of sticky status.
- `rd_data` out 32: read word.
- `rd_valid` out 1: one-cycle qualifier for `rd_data`.
- `empty` out 1: no complete entry is held.
- `level` out AW+1: number of entries held, 0..DEPTH.
- `overflow` out 1: sticky flag, set when a write is dropped.
- `ovf_cnt` out 16: dropped-write count. Present only with `TIME_CODE_OVF_CNT_EN`.

## Operation
- Circular buffer with write pointer and read pointer, each AW bits wide. Pointers wrap modulo DEPTH. `level` is a separate counter.
- **Write acceptance:** a write is accepted when `w_en`=1 and either `level`<DEPTH or an entry is popped in the same cycle.
  - An accepted write stores `w_data` at the write pointer and advances the pointer.
  - Otherwise the write is dropped, `overflow` is set, and `ovf_cnt` increments, saturating at 0xFFFF.
  - The buffer contents are never overwritten.
- **Read state machine,** 2 states:
  - RD_HI: `rd_req`=1 and `empty`=0 → `rd_data` ← entry[63:32], `rd_valid`=1, go to RD_LO. The entry is not popped.
  - RD_LO: `rd_req`=1 → `rd_data` ← entry[31:0], `rd_valid`=1, pop the entry (read pointer +1, `level` −1), go to RD_HI.
  - `rd_req` in RD_HI while `empty`=1 is ignored: `rd_valid`=0 and `rd_data` holds its value.
  - `rd_req`=0 in either state holds the state. No timeout.
- **Simultaneous write and pop:** `level` is unchanged and both pointers advance. This also applies at `level`=DEPTH, where the write is accepted and no overflow occurs.
- **`empty`** = (`level`==0).
- **`clr`**, highest priority: in the same cycle, `w_en` and `rd_req` are ignored.
  - Pointers, `level`, `overflow` and `ovf_cnt` go to 0.
  - State returns to RD_HI and `rd_valid` goes to 0.
  - A partially read entry is discarded.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `empty`=1, `level`=0, `overflow`=0, `ovf_cnt`=0, state RD_HI, pointers 0. Memory contents are don't-care.
- **Write latency:** `w_en` sampled at edge n. `level` and `empty` reflect it after edge n; the entry is readable by `rd_req` sampled at edge n+1.
- **Read latency:** `rd_req` sampled at edge k. `rd_data` and `rd_valid` are registered and valid for the cycle after edge k. `rd_valid` is a one-cycle pulse per request.
- **Throughput:** back-to-back `rd_req` yields one word per cycle, i.e. one entry per 2 cycles. Writes are accepted every cycle.
- `overflow` and `ovf_cnt` update at the edge that samples the dropped `w_en`.

## Configuration
- `TIME_CODE_OVF_CNT_EN` defined: the `ovf_cnt` port and its 16-bit saturating counter are present.
- Not defined: the port and counter are absent. `overflow` still works.

## Test plan
- **Basic read:** reset, then one `w_en` with 0x0000_0012_1DCD_6500, then `rd_req` ×2 → words 0x0000_0012 then 0x1DCD_6500, each with one-cycle `rd_valid`. Afterwards `level`=0 and `empty`=1.
- **Fill and overflow:** DEPTH+3 writes, no reads → `level`=16, `overflow`=1, `ovf_cnt`=3. Read all 32 words → entries 0..15 in order, `overflow` still 1.
- **Write at full with pop:** `level`=16 in RD_LO, `w_en` and `rd_req` in the same cycle → write accepted, `level` stays 16, `overflow` stays 0.
- **Empty read:** `rd_req` at `level`=0 → `rd_valid`=0 and state stays RD_HI.
- **Clear mid-entry:** `clr` after the high word of an entry, with 3 entries held → `level`=0, `overflow`=0. The next write and reads return the new entry, starting with its high word.
- **Reset mid-operation:** assert `rst_n` low during a `rd_valid` cycle → all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/time_code_buffer.sv
// time_code_buffer
//   Holds the 64-bit time codes from the time-code combination stage in a
//   circular buffer. Each entry is handed to the 32-bit register-read path
//   as two words: seconds first, then nanoseconds. A write is dropped when
//   the buffer is full and no entry leaves in the same cycle. Stored
//   entries are never overwritten.
//
//   Ports:
//     sclk      system clock, rising edge
//     rst_n     asynchronous active-low reset
//     w_en      single-cycle write strobe
//     w_data    time code {seconds[31:0], nanoseconds[31:0]}
//     rd_req    request for one 32-bit word
//     clr       synchronous flush; also clears sticky status
//     rd_data   registered read word
//     rd_valid  one-cycle qualifier for rd_data
//     empty     no complete entry held
//     level     entries held, 0..DEPTH
//     overflow  sticky, set when a write is dropped
//     ovf_cnt   saturating dropped-write count (TIME_CODE_OVF_CNT_EN only)
//
//   Build option: define TIME_CODE_OVF_CNT_EN to add ovf_cnt and its counter.

module time_code_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          w_en,
    input  logic [63:0]   w_data,
    input  logic          rd_req,
    input  logic          clr,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
`ifdef TIME_CODE_OVF_CNT_EN
    ,
    output logic [15:0]   ovf_cnt
`endif
);

    typedef enum logic {
        RD_HI = 1'b0,
        RD_LO = 1'b1
    } rd_state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [63:0]   head;
    logic          hi_rd;
    logic          pop;
    logic          wr_ok;
    logic          drop;

    assign head  = mem[rd_ptr];
    assign empty = (level == '0);

    // The entry stays in place while its high word is out; it only leaves
    // the buffer when the low word is read.
    always_comb begin
        state_nxt = state;
        hi_rd     = 1'b0;
        pop       = 1'b0;
        wr_ok     = 1'b0;
        drop      = 1'b0;
        if (clr) begin
            state_nxt = RD_HI;
        end else begin
            case (state)
                RD_HI: begin
                    if (rd_req && (level != '0)) begin
                        hi_rd     = 1'b1;
                        state_nxt = RD_LO;
                    end
                end
                RD_LO: begin
                    if (rd_req) begin
                        pop       = 1'b1;
                        state_nxt = RD_HI;
                    end
                end
                default: state_nxt = RD_HI;
            endcase
            // A pop in the same cycle frees a slot, so a full buffer can
            // still take the write.
            if (w_en) begin
                if ((level != FULL) || pop) begin
                    wr_ok = 1'b1;
                end else begin
                    drop  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= hi_rd | pop;
            if (hi_rd) begin
                rd_data <= head[63:32];
            end else if (pop) begin
                rd_data <= head[31:0];
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !wr_ok) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef TIME_CODE_OVF_CNT_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

    // Storage is not reset; only entries below level are ever read.
    always_ff @(posedge sclk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= w_data;
        end
    end

endmodule

// File: tb/tb_time_code_buffer.sv
module tb_time_code_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          sclk   = 1'b0;
    logic          rst_n  = 1'b1;
    logic          w_en   = 1'b0;
    logic [63:0]   w_data = '0;
    logic          rd_req = 1'b0;
    logic          clr    = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
`ifdef TIME_CODE_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of whole entries plus a flag telling whether
    // the head's high word has already been handed out.
    logic [63:0] q[$];
    bit          hi_sent = 1'b0;
    bit          m_ovf   = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_data  = '0;
    bit          m_valid = 1'b0;

    time_code_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .w_data   (w_data),
        .rd_req   (rd_req),
        .clr      (clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
`ifdef TIME_CODE_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sclk or negedge rst_n) begin
        logic [63:0] h;
        if (!rst_n) begin
            q.delete();
            hi_sent = 1'b0;
            m_ovf   = 1'b0;
            m_cnt   = 0;
            m_data  = '0;
            m_valid = 1'b0;
        end else if (clr) begin
            q.delete();
            hi_sent = 1'b0;
            m_ovf   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rd_req) begin
                if (hi_sent) begin
                    h       = q.pop_front();
                    m_data  = h[31:0];
                    m_valid = 1'b1;
                    hi_sent = 1'b0;
                end else if (q.size() > 0) begin
                    h       = q[0];
                    m_data  = h[63:32];
                    m_valid = 1'b1;
                    hi_sent = 1'b1;
                end
            end
            if (w_en) begin
                if (q.size() < DEPTH) begin
                    q.push_back(w_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
    end

    always @(negedge sclk) begin
        chk("cmp_rd_valid", 64'(rd_valid), 64'(m_valid));
        chk("cmp_rd_data",  64'(rd_data),  64'(m_data));
        chk("cmp_level",    64'(level),    64'(q.size()));
        chk("cmp_empty",    64'(empty),    64'(q.size() == 0));
        chk("cmp_overflow", 64'(overflow), 64'(m_ovf));
`ifdef TIME_CODE_OVF_CNT_EN
        chk("cmp_ovf_cnt",  64'(ovf_cnt),  64'(m_cnt));
`endif
    end

    // Inputs change 1 time unit after a rising edge; the call returns 1 unit
    // after the next rising edge, when registered outputs have settled.
    task automatic step(input bit w, input logic [63:0] d, input bit r, input bit c);
        w_en   = w;
        w_data = d;
        rd_req = r;
        clr    = c;
        @(posedge sclk);
        #1;
        w_en   = 1'b0;
        rd_req = 1'b0;
        clr    = 1'b0;
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] last_hi;
        logic [31:0] last_lo;
        int          wp;
        int          rp;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_rd_data",  64'(rd_data),  64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_empty",    64'(empty),    64'h1);
        chk("rst_level",    64'(level),    64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);

        // Basic read
        step(1'b1, 64'h0000_0012_1DCD_6500, 1'b0, 1'b0);
        chk("basic_level1", 64'(level), 64'd1);
        chk("basic_empty0", 64'(empty), 64'h0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("basic_hi_valid", 64'(rd_valid), 64'h1);
        chk("basic_hi_data",  64'(rd_data),  64'h0000_0012);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("basic_lo_valid", 64'(rd_valid), 64'h1);
        chk("basic_lo_data",  64'(rd_data),  64'h1DCD_6500);
        chk("basic_level0",   64'(level),    64'd0);
        chk("basic_empty1",   64'(empty),    64'h1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("basic_pulse", 64'(rd_valid), 64'h0);

        // Empty read: ignored, data held, state remains on the high word
        step(1'b0, '0, 1'b1, 1'b0);
        chk("empty_rd_valid", 64'(rd_valid), 64'h0);
        chk("empty_rd_hold",  64'(rd_data),  64'h1DCD_6500);
        step(1'b1, 64'h0000_0013_0000_0001, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("empty_then_hi", 64'(rd_data), 64'h0000_0013);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("empty_then_lo", 64'(rd_data), 64'h0000_0001);

        // Fill and overflow
        for (int i = 0; i < DEPTH + 3; i++) begin
            e = {32'h5000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
            step(1'b1, e, 1'b0, 1'b0);
        end
        chk("fill_level",    64'(level),    64'd16);
        chk("fill_overflow", 64'(overflow), 64'h1);
`ifdef TIME_CODE_OVF_CNT_EN
        chk("fill_ovf_cnt",  64'(ovf_cnt),  64'd3);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("fill_rd_hi", 64'(rd_data), 64'(32'h5000_0000 + 32'(i)));
            step(1'b0, '0, 1'b1, 1'b0);
            chk("fill_rd_lo", 64'(rd_data), 64'(32'hA000_0000 + 32'(i)));
        end
        chk("fill_ovf_sticky", 64'(overflow), 64'h1);
        chk("fill_drained",    64'(empty),    64'h1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_overflow", 64'(overflow), 64'h0);

        // Write at full with a simultaneous pop
        for (int i = 0; i < DEPTH; i++) begin
            e = {32'h6000_0000 + 32'(i), 32'h0C00_0000 + 32'(i)};
            step(1'b1, e, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("full_pop_hi", 64'(rd_data), 64'h6000_0000);
        step(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0);
        chk("full_pop_lo",       64'(rd_data),  64'h0C00_0000);
        chk("full_pop_level",    64'(level),    64'd16);
        chk("full_pop_overflow", 64'(overflow), 64'h0);
        last_hi = '0;
        last_lo = '0;
        for (int j = 0; j < 2 * DEPTH; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (j == 2 * DEPTH - 2) last_hi = rd_data;
            if (j == 2 * DEPTH - 1) last_lo = rd_data;
        end
        chk("full_pop_last_hi", 64'(last_hi), 64'hDEAD_BEEF);
        chk("full_pop_last_lo", 64'(last_lo), 64'h0BAD_F00D);
        chk("full_pop_empty",   64'(empty),   64'h1);

        // Clear after the high word of an entry, three entries held
        for (int i = 0; i < 3; i++) begin
            e = {32'h7000_0000 + 32'(i), 32'h7777_0000 + 32'(i)};
            step(1'b1, e, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("clr_mid_hi", 64'(rd_data), 64'h7000_0000);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_level",    64'(level),    64'd0);
        chk("clr_empty",    64'(empty),    64'h1);
        chk("clr_rd_valid", 64'(rd_valid), 64'h0);
        chk("clr_ovf",      64'(overflow), 64'h0);
        step(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("clr_new_hi", 64'(rd_data), 64'h1111_2222);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("clr_new_lo", 64'(rd_data), 64'h3333_4444);

        // Randomized traffic: write-heavy phase, then balanced
        for (int n = 0; n < 600; n++) begin
            wp = (n < 250) ? 70 : 45;
            rp = (n < 250) ? 30 : 60;
            step(($urandom_range(0, 99) < wp), {$urandom, $urandom},
                 ($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset during a rd_valid cycle
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 64'h0000_0099_0000_0042, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_valid", 64'(rd_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_valid", 64'(rd_valid), 64'h0);
        chk("arst_rd_data",  64'(rd_data),  64'h0);
        chk("arst_level",    64'(level),    64'h0);
        chk("arst_empty",    64'(empty),    64'h1);
        chk("arst_overflow", 64'(overflow), 64'h0);
`ifdef TIME_CODE_OVF_CNT_EN
        chk("arst_ovf_cnt",  64'(ovf_cnt),  64'h0);
`endif
        @(posedge sclk);
        #1 rst_n = 1'b1;
        step(1'b1, 64'h0000_00AA_0000_00BB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_hi", 64'(rd_data), 64'h0000_00AA);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_lo", 64'(rd_data), 64'h0000_00BB);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
